// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache fill engine.
package icache_pkg;

  localparam int ICACHE_BLOCKSIZE = 4;
  localparam int ICACHE_OFFBITS   = $clog2(ICACHE_BLOCKSIZE);

  typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;

  typedef enum logic {WAY1 = 1'b0, WAY2 = 1'b1} way_sel_t;

  // Invalid ways are filled first; otherwise replace the way not filled most recently.
  function automatic way_sel_t pickVictim(input logic w1v, input logic w2v, input logic lru);
    if (!w1v)     return WAY1;
    else if (!w2v) return WAY2;
    else if (lru) return WAY1;
    else          return WAY2;
  endfunction

endpackage

// File: rtl/icache_fill_controller_if.sv
// Pipeline, cache-memory and AHB-lite signals seen by the fill controller.
interface icache_fill_controller_if
  import icache_pkg::*;
#(
  parameter int OFFBITS = ICACHE_OFFBITS
);
  logic               Req;
  logic [31:0]        A;
  logic               W1Hit;
  logic               W2Hit;
  logic               W1V;
  logic               W2V;
  logic               CurrLRU;
  logic               HReady;
  logic [31:0]        ANew;
  logic [OFFBITS-1:0] WordOffset;
  logic               W1WE;
  logic               W2WE;
  logic [31:0]        HAddr;
  logic               HRequest;
  logic               Stall;

  modport master (
    input  Req, A, W1Hit, W2Hit, W1V, W2V, CurrLRU, HReady,
    output ANew, WordOffset, W1WE, W2WE, HAddr, HRequest, Stall
  );

  modport slave (
    output Req, A, W1Hit, W2Hit, W1V, W2V, CurrLRU, HReady,
    input  ANew, WordOffset, W1WE, W2WE, HAddr, HRequest, Stall
  );
endinterface

// File: rtl/icache_word_counter.sv
// Wrapping word-offset counter for a line fill; o_done flags the enable that writes the last word.
module icache_word_counter #(
  parameter int BLOCKSIZE = 4,
  localparam int OFFBITS  = $clog2(BLOCKSIZE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [OFFBITS-1:0] i_loadVal,
  input  logic               i_en,
  output logic [OFFBITS-1:0] o_cnt,
  output logic               o_done
);

  logic [OFFBITS-1:0] r_cnt;
  logic [OFFBITS-1:0] r_wordsDone;

  // BLOCKSIZE is a power of two, so natural overflow gives the modulo wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_wordsDone <= '0;
    end else if (i_load) begin
      r_cnt       <= i_loadVal;
      r_wordsDone <= '0;
    end else if (i_en) begin
      r_cnt       <= r_cnt + 1'b1;
      r_wordsDone <= r_wordsDone + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_done = i_en && (r_wordsDone == OFFBITS'(BLOCKSIZE - 1));

endmodule

// File: rtl/icache_fill_controller.sv
// Miss handler for the 2-way icache: stalls fetch, bursts a line over AHB-lite into the victim way.
// Optional: ICACHE_CRITICAL_WORD_FIRST_EN starts the burst at the missed word and wraps.
module icache_fill_controller
  import icache_pkg::*;
#(
  parameter int BLOCKSIZE = ICACHE_BLOCKSIZE,
  localparam int OFFBITS  = $clog2(BLOCKSIZE)
) (
  input  logic                      clk,
  input  logic                      reset,
  icache_fill_controller_if.master  bus
);

  fill_state_t        r_state;
  logic [31:0]        r_missAddr;
  way_sel_t           r_victim;
  logic               r_hRequest;

  logic               w_miss;
  logic               w_load;
  logic               w_fillEn;
  logic               w_lastWord;
  logic [OFFBITS-1:0] w_cnt;
  logic [OFFBITS-1:0] w_startWord;
  logic [31:0]        w_fillAddr;

  assign w_miss   = bus.Req && !bus.W1Hit && !bus.W2Hit;
  assign w_load   = (r_state == IDLE) && w_miss;
  assign w_fillEn = (r_state == FILL) && bus.HReady;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign w_startWord = bus.A[OFFBITS+1:2];
`else
  assign w_startWord = '0;
`endif

  icache_word_counter #(.BLOCKSIZE(BLOCKSIZE)) u_counter (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_loadVal (w_startWord),
    .i_en      (w_fillEn),
    .o_cnt     (w_cnt),
    .o_done    (w_lastWord)
  );

  assign w_fillAddr = {r_missAddr[31:OFFBITS+2], w_cnt, 2'b00};

  // The bus request is registered: raised on the miss edge, dropped when the last word lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_missAddr <= '0;
      r_victim   <= WAY1;
      r_hRequest <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_state    <= FILL;
            r_missAddr <= bus.A;
            r_victim   <= pickVictim(bus.W1V, bus.W2V, bus.CurrLRU);
            r_hRequest <= 1'b1;
          end
        end
        FILL: begin
          if (w_lastWord) begin
            r_state    <= DONE;
            r_hRequest <= 1'b0;
          end
        end
        DONE: r_state <= IDLE;
        default: begin
          r_state    <= IDLE;
          r_hRequest <= 1'b0;
        end
      endcase
    end
  end

  // Write enables and addressing must track HReady in the same cycle the data is on the bus.
  always_comb begin
    bus.ANew       = bus.A;
    bus.WordOffset = bus.A[OFFBITS+1:2];
    bus.HAddr      = '0;
    bus.Stall      = w_miss;
    bus.W1WE       = 1'b0;
    bus.W2WE       = 1'b0;
    case (r_state)
      FILL: begin
        bus.ANew       = w_fillAddr;
        bus.WordOffset = w_cnt;
        bus.HAddr      = w_fillAddr;
        bus.Stall      = 1'b1;
        bus.W1WE       = w_fillEn && (r_victim == WAY1);
        bus.W2WE       = w_fillEn && (r_victim == WAY2);
      end
      DONE: begin
        bus.ANew       = r_missAddr;
        bus.WordOffset = r_missAddr[OFFBITS+1:2];
        bus.Stall      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.HRequest = r_hRequest;

endmodule

// File: tb/tb_icache_fill_controller.sv
// Directed self-checking bench for icache_fill_controller (honours ICACHE_CRITICAL_WORD_FIRST_EN).
module tb_icache_fill_controller;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   assertCount = 0;
  int   failCount   = 0;

  always #5 clk = ~clk;

  icache_fill_controller_if bus();

  icache_fill_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [31:0] a, input logic w1hit, input logic w2hit,
                               input logic w1v, input logic w2v, input logic lru, input logic hready);
    bus.Req     = req;
    bus.A       = a;
    bus.W1Hit   = w1hit;
    bus.W2Hit   = w2hit;
    bus.W1V     = w1v;
    bus.W2V     = w2v;
    bus.CurrLRU = lru;
    bus.HReady  = hready;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One complete miss; gapLen HReady-low cycles are inserted after the first word.
  task automatic runMiss(input logic [31:0] addr, input logic w1v, input logic w2v, input logic lru,
                         input logic expWay, input int gapLen);
    int          stallCycles = 0;
    int          words = 0;
    int          gapLeft = gapLen;
    int          expCnt;
    logic        hr;
    logic [31:0] base;
    logic [31:0] expAddr;
    base = {addr[31:4], 4'b0000};
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    expCnt = int'(addr[3:2]);
`else
    expCnt = 0;
`endif
    applyStimulus(1'b1, addr, 1'b0, 1'b0, w1v, w2v, lru, 1'b1);
    #2;
    checkOutput("idle_miss_stall", 32'(bus.Stall), 32'd1);
    checkOutput("idle_hrequest", 32'(bus.HRequest), 32'd0);
    checkOutput("idle_anew", bus.ANew, addr);
    if (bus.Stall) stallCycles++;
    nextCycle();
    applyStimulus(1'b0, 32'hDEAD_BEE0, 1'b0, 1'b0, w1v, w2v, lru, 1'b1);
    for (int c = 0; c < 20 && words < 4; c++) begin
      hr = !(words == 1 && gapLeft > 0);
      if (!hr) gapLeft--;
      bus.HReady = hr;
      #2;
      expAddr = base | 32'(expCnt << 2);
      checkOutput("fill_stall", 32'(bus.Stall), 32'd1);
      checkOutput("fill_hrequest", 32'(bus.HRequest), 32'd1);
      checkOutput("fill_haddr", bus.HAddr, expAddr);
      checkOutput("fill_anew", bus.ANew, expAddr);
      checkOutput("fill_wordoffset", 32'(bus.WordOffset), 32'(expCnt));
      checkOutput("fill_w1we", 32'(bus.W1WE), 32'(hr && !expWay));
      checkOutput("fill_w2we", 32'(bus.W2WE), 32'(hr && expWay));
      if (bus.Stall) stallCycles++;
      if (hr) begin
        words++;
        expCnt = (expCnt + 1) % 4;
      end
      nextCycle();
    end
    #2;
    checkOutput("done_stall", 32'(bus.Stall), 32'd1);
    checkOutput("done_hrequest", 32'(bus.HRequest), 32'd0);
    checkOutput("done_anew", bus.ANew, addr);
    checkOutput("done_we", {30'd0, bus.W2WE, bus.W1WE}, 32'd0);
    if (bus.Stall) stallCycles++;
    nextCycle();
    applyStimulus(1'b1, addr, !expWay, expWay, 1'b1, 1'b1, lru, 1'b1);
    #2;
    checkOutput("rehit_stall", 32'(bus.Stall), 32'd0);
    if (bus.Stall) stallCycles++;
    checkOutput("stall_cycles", 32'(stallCycles), 32'(6 + gapLen));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    nextCycle();
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    checkOutput("reset_stall", 32'(bus.Stall), 32'd0);
    checkOutput("reset_hrequest", 32'(bus.HRequest), 32'd0);
    checkOutput("reset_haddr", bus.HAddr, 32'd0);
    checkOutput("reset_we", {30'd0, bus.W2WE, bus.W1WE}, 32'd0);
    applyStimulus(1'b1, 32'h0000_100C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("reset_miss_stall", 32'(bus.Stall), 32'd1);
    checkOutput("reset_anew", bus.ANew, 32'h0000_100C);
    checkOutput("reset_wordoffset", 32'(bus.WordOffset), 32'd3);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    reset = 1'b0;
    nextCycle();

    runMiss(32'h0000_1008, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    runMiss(32'h0000_2010, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    runMiss(32'h0000_2010, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    runMiss(32'h0000_3018, 1'b1, 1'b0, 1'b0, 1'b1, 2);

    applyStimulus(1'b1, 32'h0000_2344, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    #2;
    checkOutput("hit_stall", 32'(bus.Stall), 32'd0);
    checkOutput("hit_hrequest", 32'(bus.HRequest), 32'd0);
    checkOutput("hit_wordoffset", 32'(bus.WordOffset), 32'd1);
    checkOutput("hit_anew", bus.ANew, 32'h0000_2344);
    nextCycle();

    // Reset while the third word is on the bus.
    applyStimulus(1'b1, 32'h0000_3004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    nextCycle();
    #2;
    checkOutput("abort_pre_w1we", 32'(bus.W1WE), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort_w1we", 32'(bus.W1WE), 32'd0);
    checkOutput("abort_w2we", 32'(bus.W2WE), 32'd0);
    checkOutput("abort_hrequest", 32'(bus.HRequest), 32'd0);
    checkOutput("abort_stall", 32'(bus.Stall), 32'd0);
    checkOutput("abort_haddr", bus.HAddr, 32'd0);
    nextCycle();
    reset = 1'b0;
    nextCycle();
    runMiss(32'h0000_1008, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
